// File: rtl/alu_exec_ctrl_if.sv
// Bundle of decode-side, ALU-side and writeback-side signals around alu_exec_ctrl.
// slave = the controller, master = the surrounding datapath.
interface alu_exec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [4:0]  in_op;
    logic        in_s;
    logic [3:0]  in_rd;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [4:0]  alu_operation;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        alu_wb;

    logic        wb_valid;
    logic        wb_ready;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  cpsr_flags;

    modport slave (
        input  in_valid, in_cond, in_op, in_s, in_rd, in_a, in_b,
        input  alu_result, alu_flags, alu_wb,
        input  wb_ready,
        output in_ready,
        output alu_data1, alu_data2, alu_operation,
        output wb_valid, wb_en, wb_rd, wb_data,
        output cpsr_flags
    );

    modport master (
        output in_valid, in_cond, in_op, in_s, in_rd, in_a, in_b,
        output alu_result, alu_flags, alu_wb,
        output wb_ready,
        input  in_ready,
        input  alu_data1, alu_data2, alu_operation,
        input  wb_valid, wb_en, wb_rd, wb_data,
        input  cpsr_flags
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// One-op-in-flight sequencer around the combinational ALU: accept, condition-check
// and execute, then hold the writeback slot until the register file takes it.
module alu_exec_ctrl (
    input  logic          clk,
    input  logic          reset,
    alu_exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_in_ready;
    logic        w_wb_valid;
    logic        w_accept;
    logic        w_retire;

    logic [3:0]  r_cond;
    logic [4:0]  r_op;
    logic        r_s;
    logic [3:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic        r_wb_en;
    logic [31:0] r_wb_data;
    logic [3:0]  r_flags_nxt;
    logic [3:0]  r_cpsr;

    logic        w_pass;
    logic        w_flag_upd;
    logic [3:0]  w_flags_nxt;

    // Flag bit order: [0]=Z, [1]=C, [2]=N, [3]=V
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic z, c, n, v;
        z = f[0];
        c = f[1];
        n = f[2];
        v = f[3];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_wb_valid  = 1'b0;
        w_accept    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = WB;
            WB: begin
                w_wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Compare ops (TST/TEQ/CMP/CMN, 010xx) set flags regardless of S.
    // The ALU never produces C, so it is always carried over from the CPSR.
    assign w_pass      = cond_pass(r_cond, r_cpsr);
    assign w_flag_upd  = w_pass & (r_s | (r_op[4:2] == 3'b010));
    assign w_flags_nxt = w_flag_upd ? {bus.alu_flags[3], bus.alu_flags[2], r_cpsr[1], bus.alu_flags[0]}
                                    : r_cpsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond      <= '0;
            r_op        <= '0;
            r_s         <= 1'b0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_wb_en     <= 1'b0;
            r_wb_data   <= '0;
            r_flags_nxt <= '0;
            r_cpsr      <= '0;
        end else begin
            if (w_accept) begin
                r_cond <= bus.in_cond;
                r_op   <= bus.in_op;
                r_s    <= bus.in_s;
                r_rd   <= bus.in_rd;
                r_a    <= bus.in_a;
                r_b    <= bus.in_b;
            end
            if (r_state == EXEC) begin
                r_wb_data   <= bus.alu_result;
                r_wb_en     <= w_pass & bus.alu_wb;
                r_flags_nxt <= w_flags_nxt;
            end
            // Flags become architectural only once the slot is handed off.
            if (w_retire) begin
                r_cpsr  <= r_flags_nxt;
                r_wb_en <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.alu_data1     = r_a;
    assign bus.alu_data2     = r_b;
    assign bus.alu_operation = r_op;
    assign bus.wb_valid      = w_wb_valid;
    assign bus.wb_en         = r_wb_en;
    assign bus.wb_rd         = r_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.cpsr_flags    = r_cpsr;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small ALU model and an expected-result queue.
module tb_alu_exec_ctrl;
    logic clk;
    logic reset;

    alu_exec_ctrl_if bus();

    alu_exec_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ALU model: only the opcodes exercised here; C is never produced.
    always_comb begin
        logic [31:0] a, b, r;
        logic        v;
        a = bus.alu_data1;
        b = bus.alu_data2;
        r = 32'h0;
        v = 1'b0;
        bus.alu_wb = 1'b0;
        case (bus.alu_operation)
            5'b00000: begin r = a & b; bus.alu_wb = 1'b1; end
            5'b00010: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); bus.alu_wb = 1'b1; end
            5'b00100: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); bus.alu_wb = 1'b1; end
            5'b01010: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'b01101: begin r = b; bus.alu_wb = 1'b1; end
            default:  begin r = 32'h0; end
        endcase
        bus.alu_result = r;
        bus.alu_flags  = {v, r[31], 1'b0, (r == 32'h0)};
    end

    typedef struct {
        logic        en;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sbq[$];
    int         nchk  = 0;
    int         npass = 0;
    logic [3:0] cur_flags = 4'b0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [3:0] cond, input logic [4:0] op, input logic s,
                          input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_en, input logic [31:0] exp_data,
                          input logic [3:0] exp_flags, input int stall);
        exp_t e;
        e.en = exp_en; e.rd = rd; e.data = exp_data; e.flags = exp_flags;
        sbq.push_back(e);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_cond  = cond;
        bus.in_op    = op;
        bus.in_s     = s;
        bus.in_rd    = rd;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        // EXEC cycle: garbage on in_* must be ignored
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEADBEEF;
        bus.in_b     = 32'hCAFEF00D;
        bus.in_op    = 5'b11111;
        chk("exec_in_ready", bus.in_ready, 0);
        chk("exec_wb_valid", bus.wb_valid, 0);
        chk("exec_alu_op", bus.alu_operation, op);
        chk("exec_alu_d1", bus.alu_data1, a);
        chk("exec_alu_d2", bus.alu_data2, b);
        @(negedge clk);
        for (int k = 0; k < stall; k++) begin
            bus.wb_ready = 1'b0;
            chk("stall_wb_valid", bus.wb_valid, 1);
            chk("stall_wb_data", bus.wb_data, exp_data);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_cpsr", bus.cpsr_flags, cur_flags);
            @(negedge clk);
        end
        bus.wb_ready = 1'b1;
        chk("wb_valid", bus.wb_valid, 1);
        if (sbq.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("wb_en", bus.wb_en, e.en);
            chk("wb_rd", bus.wb_rd, e.rd);
            chk("wb_data", bus.wb_data, e.data);
            chk("cpsr_before_commit", bus.cpsr_flags, cur_flags);
            @(negedge clk);
            chk("cpsr_after_commit", bus.cpsr_flags, e.flags);
            chk("post_wb_valid", bus.wb_valid, 0);
            chk("post_in_ready", bus.in_ready, 1);
            cur_flags = e.flags;
        end
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cond  = 4'h0;
        bus.in_op    = 5'h0;
        bus.in_s     = 1'b0;
        bus.in_rd    = 4'h0;
        bus.in_a     = 32'h0;
        bus.in_b     = 32'h0;
        bus.wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_en", bus.wb_en, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_cpsr", bus.cpsr_flags, 0);
        chk("rst_alu_d1", bus.alu_data1, 0);
        chk("rst_alu_d2", bus.alu_data2, 0);
        chk("rst_alu_op", bus.alu_operation, 0);

        // cond, op, s, rd, a, b, exp_en, exp_data, exp_flags, stall
        run_op(4'b1110, 5'b00100, 1, 4'd2, 32'd3, 32'd7, 1, 32'd10, 4'b0000, 0);         // ADD S
        run_op(4'b1110, 5'b01010, 0, 4'd0, 32'd7, 32'd7, 0, 32'd0, 4'b0001, 0);          // CMP equal
        run_op(4'b0000, 5'b01101, 0, 4'd3, 32'd0, 32'd5, 1, 32'd5, 4'b0001, 0);          // MOVEQ
        run_op(4'b0001, 5'b01101, 0, 4'd4, 32'd0, 32'd9, 0, 32'd9, 4'b0001, 0);          // MOVNE fails
        run_op(4'b1110, 5'b00010, 0, 4'd5, 32'd3, 32'd7, 1, 32'hFFFFFFFC, 4'b0001, 0);   // SUB
        run_op(4'b1110, 5'b00010, 1, 4'd5, 32'd3, 32'd7, 1, 32'hFFFFFFFC, 4'b0100, 0);   // SUBS
        run_op(4'b1110, 5'b00100, 1, 4'd6, 32'd1, 32'd1, 1, 32'd2, 4'b0000, 3);          // ADDS, stalled
        run_op(4'b1111, 5'b00100, 1, 4'd7, 32'd0, 32'd0, 0, 32'd0, 4'b0000, 0);          // never
        run_op(4'b1110, 5'b00100, 1, 4'd7, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 4'b1100, 0); // overflow
        run_op(4'b1100, 5'b01101, 0, 4'd8, 32'd0, 32'h11, 1, 32'h11, 4'b1100, 0);        // MOVGT
        run_op(4'b1011, 5'b01101, 0, 4'd8, 32'd0, 32'h22, 0, 32'h22, 4'b1100, 0);        // MOVLT fails
        run_op(4'b1110, 5'b10000, 1, 4'd9, 32'd5, 32'd6, 0, 32'd0, 4'b0001, 0);          // unsupported

        // Reset while an S=1 op is in EXEC: op is dropped, flags back to zero.
        bus.in_valid = 1'b1;
        bus.in_cond  = 4'b1110;
        bus.in_op    = 5'b00100;
        bus.in_s     = 1'b1;
        bus.in_rd    = 4'd10;
        bus.in_a     = 32'h80000000;
        bus.in_b     = 32'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rexec_wb_valid", bus.wb_valid, 0);
        chk("rexec_in_ready", bus.in_ready, 1);
        chk("rexec_cpsr", bus.cpsr_flags, 0);
        chk("rexec_wb_en", bus.wb_en, 0);
        chk("rexec_alu_d1", bus.alu_data1, 0);
        cur_flags = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rexec_no_wb", bus.wb_valid, 0);
        end

        // Reset and in_valid together: nothing latched.
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h1234;
        bus.in_op    = 5'b00100;
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("rboth_in_ready", bus.in_ready, 1);
        chk("rboth_alu_d1", bus.alu_data1, 0);
        @(negedge clk);
        chk("rboth_wb_valid", bus.wb_valid, 0);
        chk("rboth_in_ready2", bus.in_ready, 1);

        run_op(4'b1110, 5'b00100, 0, 4'd1, 32'd2, 32'd2, 1, 32'd4, 4'b0000, 0);          // recovery

        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Sequencing controller that wraps the combinational ALU in the ARM datapath. Accepts one decoded data-processing micro-op at a time over a valid/ready handshake. Evaluates the ARM condition field against an internally held CPSR flag register, then drives the ALU. It captures the result, presents it to the register-file writeback port with backpressure, and commits NZCV when the op requests it. Sits between the decode stage and the register file.

## Interface

Parameters:
- none (data width fixed at 32, opcode width fixed at 5)

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  in  1  decode presents a micro-op
- in_ready  out  1  controller can accept a micro-op this cycle
- in_cond  in  4  ARM condition field
- in_op  in  5  ALU operation code, same encoding the ALU uses
- in_s  in  1  S bit (set flags)
- in_rd  in  4  destination register index
- in_a, in_b  in  32  operand 1 (Rn) and operand 2 (shifted)
- alu_data1, alu_data2  out  32  operands to ALU
- alu_operation  out  5  opcode to ALU
- alu_result  in  32  ALU result
- alu_flags  in  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V
- alu_wb  in  1  ALU's writeback-allowed indication
- wb_valid  out  1  writeback slot presented
- wb_ready  in  1  register file accepts slot
- wb_en  out  1  slot actually writes rd (0 = retired without write)
- wb_rd  out  4  destination index
- wb_data  out  32  value to write
- cpsr_flags  out  4  committed flags, same bit order as alu_flags

## Operation

- FSM states: IDLE, EXEC, WB. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch cond, op, s, rd, a and b; go to EXEC. Otherwise stay.
- EXEC: in_ready=0. alu_data1/alu_data2/alu_operation driven from latched registers; these hold those values in all states (0 after reset).
  - Condition evaluated against cpsr_flags using the ARM table: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
  - At the clock edge, capture:
    - pass
    - wb_data=alu_result
    - wb_en=pass&alu_wb
    - next flags
  - Go to WB.
- Flag commit rule: update only if pass and (in_s=1 or op is TST/TEQ/CMP/CMN, codes 01000–01011).
  - Z, N and V are taken from alu_flags.
  - C is always preserved from cpsr_flags; the ALU does not drive C.
- Failed condition: op still passes through WB with wb_en=0, flags unchanged, wb_data=alu_result (don't-care to consumer).
- Unsupported opcodes (ALU returns 0, alu_wb=0): retire with wb_en=0; flags update per rule (Z=1, N=0, V=0) if S set.
- WB: wb_valid=1, wb_en/wb_rd/wb_data stable.
  - Exit WB when wb_valid&wb_ready: go to IDLE, and the captured flags are written to cpsr_flags at that edge.
  - Otherwise hold all outputs and do not commit flags.
- Strictly one op in flight; the next op's condition always sees the previous op's committed flags (no hazard logic needed).

## Timing

- Reset values: state IDLE, in_ready=1, wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, cpsr_flags=4'b0000, alu_* outputs 0.
- Accept edge T (IDLE, in_valid=1). EXEC during cycle T+1. wb_valid=1 from T+2.
- With wb_ready=1: retire and flag commit at end of T+2. in_ready=1 in T+3.
- Throughput: one op per 3 cycles minimum. Each cycle of wb_ready=0 adds one cycle.
- in_ready is combinational from state only, never from in_valid.
- Reset in any state, including WB with wb_ready=0: the op is dropped, no flag commit, and reset values apply next cycle.
- reset and in_valid in the same cycle: reset wins, nothing latched.
- Inputs in_* are ignored outside IDLE. alu_* inputs are sampled only in EXEC.

## Test plan

- ADD (00100) a=3, b=7, S=1, AL, rd=2 → wb_valid at T+2, wb_en=1, wb_rd=2, wb_data=10, cpsr_flags=0000 after retire.
- CMP (01010) a=7, b=7, AL → wb_en=0, cpsr Z=1 (0001). Then MOV (01101) b=5, EQ → wb_en=1, data 5. Then MOV, NE → wb_en=0, flags unchanged.
- SUB a=3, b=7, S=0 → wb_data=0xFFFFFFFC, cpsr_flags unchanged. Same op with S=1 → N=1 (0100), C bit preserved from prior value.
- Hold wb_ready=0 for 3 cycles in WB → wb_valid/data stable, in_ready=0, cpsr not updated until the handshake cycle; retire on cycle 6 after accept.
- Assert reset during EXEC of an S=1 ADD → next cycle IDLE, wb_valid=0, cpsr_flags=0000, no writeback ever produced.
- cond=1111 with ADD S=1 → wb_en=0, flags unchanged. Opcode 10000 with S=1 → wb_en=0, cpsr_flags=0001 (C preserved).
